// File: rtl/hwpf_nl_issue.sv
// Next-line prefetch issue stage: pops the prefetch FIFO head, forms the next
// cache-line address, drops page-crossing candidates and issues to the dcache.
module hwpf_nl_issue #(
    parameter int ADDR_WIDTH      = 40,
    parameter int LANE_SIZE       = 64,
    parameter int PAGE_SIZE       = 4096,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TID_WIDTH       = 7
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   flush_i,
    input  logic                                   enable_i,
    input  logic                                   fifo_valid_i,
    input  logic [ADDR_WIDTH-1:0]                  fifo_addr_i,
    output logic                                   fifo_read_o,
    input  logic                                   cpu_busy_i,
    output logic                                   pf_req_valid_o,
    input  logic                                   pf_req_ready_i,
    output logic [ADDR_WIDTH-1:0]                  pf_req_addr_o,
    output logic [TID_WIDTH-1:0]                   pf_req_tid_o,
    input  logic                                   pf_rsp_valid_i,
    input  logic [TID_WIDTH-1:0]                   pf_rsp_tid_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
    output logic                                   dropped_o
);

    localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int OFF_W  = $clog2(LANE_SIZE);
    localparam int PAGE_W = $clog2(PAGE_SIZE);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ARB,
        ISSUE
    } state_t;

    state_t                state_q;
    logic [TID_WIDTH-1:0]  tid_q;
    logic [ADDR_WIDTH-1:0] line_addr;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic                  page_cross;
    logic                  handshake;
    logic                  rsp_dec;

    // The response ID and the line-offset bits carry no information here.
    logic unused_inputs;
    assign unused_inputs = ^{pf_rsp_tid_i, fifo_addr_i[OFF_W-1:0]};

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        line_addr  = '0;
        line_addr  = {fifo_addr_i[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
        next_addr  = line_addr + ADDR_WIDTH'(LANE_SIZE);
        page_cross = next_addr[ADDR_WIDTH-1:PAGE_W] != fifo_addr_i[ADDR_WIDTH-1:PAGE_W];
        handshake  = pf_req_valid_o & pf_req_ready_i;
        rsp_dec    = pf_rsp_valid_i && (outstanding_o != '0);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            fifo_read_o    <= 1'b0;
            pf_req_valid_o <= 1'b0;
            pf_req_addr_o  <= '0;
            pf_req_tid_o   <= '0;
            dropped_o      <= 1'b0;
        end else begin
            fifo_read_o <= 1'b0;
            dropped_o   <= 1'b0;
            if (flush_i) begin
                // Abort whatever is pending; counters are handled separately.
                state_q        <= IDLE;
                pf_req_valid_o <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (enable_i && (outstanding_o < MAX_CNT)) begin
                            fifo_read_o <= 1'b1;
                            state_q     <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (!fifo_valid_i) begin
                            state_q <= IDLE;
                        end else if (page_cross) begin
                            dropped_o <= 1'b1;
                            state_q   <= IDLE;
                        end else begin
                            pf_req_addr_o <= next_addr;
                            state_q       <= ARB;
                        end
                    end
                    ARB: begin
                        if (!cpu_busy_i) begin
                            pf_req_valid_o <= 1'b1;
                            pf_req_tid_o   <= tid_q;
                            state_q        <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        if (pf_req_ready_i) begin
                            pf_req_valid_o <= 1'b0;
                            state_q        <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // A handshake counts even when it coincides with a flush.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tid_q         <= '0;
            outstanding_o <= '0;
        end else begin
            if (handshake) begin
                tid_q <= tid_q + TID_WIDTH'(1);
            end
            if (handshake && !pf_rsp_valid_i) begin
                outstanding_o <= outstanding_o + CNT_W'(1);
            end else if (!handshake && rsp_dec) begin
                outstanding_o <= outstanding_o - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hwpf_nl_issue.sv
// Scoreboard bench for hwpf_nl_issue: directed vectors push expected requests,
// a negedge monitor pops and compares on every request handshake.
module tb_hwpf_nl_issue;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        enable_i;
    logic        fifo_valid_i;
    logic [39:0] fifo_addr_i;
    logic        fifo_read_o;
    logic        cpu_busy_i;
    logic        pf_req_valid_o;
    logic        pf_req_ready_i;
    logic [39:0] pf_req_addr_o;
    logic [6:0]  pf_req_tid_o;
    logic        pf_rsp_valid_i;
    logic [6:0]  pf_rsp_tid_i;
    logic [2:0]  outstanding_o;
    logic        dropped_o;

    hwpf_nl_issue dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .flush_i        (flush_i),
        .enable_i       (enable_i),
        .fifo_valid_i   (fifo_valid_i),
        .fifo_addr_i    (fifo_addr_i),
        .fifo_read_o    (fifo_read_o),
        .cpu_busy_i     (cpu_busy_i),
        .pf_req_valid_o (pf_req_valid_o),
        .pf_req_ready_i (pf_req_ready_i),
        .pf_req_addr_o  (pf_req_addr_o),
        .pf_req_tid_o   (pf_req_tid_o),
        .pf_rsp_valid_i (pf_rsp_valid_i),
        .pf_rsp_tid_i   (pf_rsp_tid_i),
        .outstanding_o  (outstanding_o),
        .dropped_o      (dropped_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [39:0] addr;
        logic [6:0]  tid;
    } req_t;

    req_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [6:0]  exp_tid = '0;
    logic [2:0]  exp_out = '0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Monitor: compares every handshake against the scoreboard and checks
    // that a stalled request holds address and ID.
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [39:0] prev_addr  = '0;
    logic [6:0]  prev_tid   = '0;
    req_t        mon_exp;

    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (pf_req_valid_o && pf_req_ready_i) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected", 64'(1), 64'(0));
                end else begin
                    mon_exp = sb.pop_front();
                    check("sb_addr", 64'(pf_req_addr_o), 64'(mon_exp.addr));
                    check("sb_tid", 64'(pf_req_tid_o), 64'(mon_exp.tid));
                end
            end
            if (prev_valid && !prev_ready && pf_req_valid_o) begin
                check("stall_addr", 64'(pf_req_addr_o), 64'(prev_addr));
                check("stall_tid", 64'(pf_req_tid_o), 64'(prev_tid));
            end
        end
        prev_valid = pf_req_valid_o;
        prev_ready = pf_req_ready_i;
        prev_addr  = pf_req_addr_o;
        prev_tid   = pf_req_tid_o;
    end

    // One pop/translate/arbitrate/issue sequence with a hand-computed result.
    task automatic issue_one(input string nm, input logic fv, input logic [39:0] a,
                             input logic exp_drop, input logic [39:0] exp_a,
                             input int busy_n, input int stall_n, input bit complete,
                             input bit rsp_f, input bit flush_f);
        fifo_valid_i   = fv;
        fifo_addr_i    = a;
        cpu_busy_i     = (busy_n > 0);
        pf_req_ready_i = 1'b0;
        enable_i       = 1'b1;
        step(1);
        check({nm, "_pop"}, 64'(fifo_read_o), 64'(1));
        enable_i = 1'b0;
        step(1);
        check({nm, "_pop_pulse"}, 64'(fifo_read_o), 64'(0));
        if (!fv || exp_drop) begin
            check({nm, "_drop"}, 64'(dropped_o), 64'(exp_drop));
            check({nm, "_novalid"}, 64'(pf_req_valid_o), 64'(0));
            step(1);
            check({nm, "_drop_pulse"}, 64'(dropped_o), 64'(0));
            check({nm, "_out"}, 64'(outstanding_o), 64'(exp_out));
            return;
        end
        check({nm, "_nodrop"}, 64'(dropped_o), 64'(0));
        if (complete) sb.push_back('{addr: exp_a, tid: exp_tid});
        repeat (busy_n) begin
            step(1);
            check({nm, "_yield"}, 64'(pf_req_valid_o), 64'(0));
        end
        cpu_busy_i = 1'b0;
        step(1);
        check({nm, "_valid"}, 64'(pf_req_valid_o), 64'(1));
        check({nm, "_addr"}, 64'(pf_req_addr_o), 64'(exp_a));
        if (!complete) return;
        cpu_busy_i = (stall_n > 0);
        repeat (stall_n) begin
            step(1);
            check({nm, "_hold"}, 64'(pf_req_valid_o), 64'(1));
        end
        cpu_busy_i     = 1'b0;
        pf_req_ready_i = 1'b1;
        pf_rsp_valid_i = rsp_f;
        flush_i        = flush_f;
        step(1);
        pf_req_ready_i = 1'b0;
        pf_rsp_valid_i = 1'b0;
        flush_i        = 1'b0;
        exp_tid        = exp_tid + 7'd1;
        if (!rsp_f) exp_out = exp_out + 3'd1;
        check({nm, "_done"}, 64'(pf_req_valid_o), 64'(0));
        check({nm, "_out"}, 64'(outstanding_o), 64'(exp_out));
    endtask

    task automatic respond(input int n);
        repeat (n) begin
            pf_rsp_valid_i = 1'b1;
            step(1);
            pf_rsp_valid_i = 1'b0;
            if (exp_out != 0) exp_out = exp_out - 3'd1;
        end
    endtask

    initial begin
        rst_i          = 1'b1;
        flush_i        = 1'b0;
        enable_i       = 1'b0;
        fifo_valid_i   = 1'b0;
        fifo_addr_i    = '0;
        cpu_busy_i     = 1'b0;
        pf_req_ready_i = 1'b0;
        pf_rsp_valid_i = 1'b0;
        pf_rsp_tid_i   = '0;
        #3;
        check("rst_read", 64'(fifo_read_o), 64'(0));
        check("rst_valid", 64'(pf_req_valid_o), 64'(0));
        check("rst_addr", 64'(pf_req_addr_o), 64'(0));
        check("rst_tid", 64'(pf_req_tid_o), 64'(0));
        check("rst_out", 64'(outstanding_o), 64'(0));
        check("rst_drop", 64'(dropped_o), 64'(0));
        step(2);
        rst_i = 1'b0;
        step(1);

        issue_one("basic", 1'b1, 40'h0000_1010, 1'b0, 40'h0000_1040, 0, 0, 1, 0, 0);
        issue_one("pgx",   1'b1, 40'h0000_1FC8, 1'b1, 40'h0, 0, 0, 1, 0, 0);
        issue_one("wrap_pgx", 1'b1, 40'hFF_FFFF_FFC0, 1'b1, 40'h0, 0, 0, 1, 0, 0);
        issue_one("empty", 1'b0, 40'h0000_1010, 1'b0, 40'h0, 0, 0, 1, 0, 0);
        issue_one("yield", 1'b1, 40'h0000_2000, 1'b0, 40'h0000_2040, 5, 0, 1, 0, 0);
        issue_one("stall", 1'b1, 40'h0000_3100, 1'b0, 40'h0000_3140, 0, 3, 1, 0, 0);
        issue_one("fill",  1'b1, 40'h0000_4000, 1'b0, 40'h0000_4040, 0, 0, 1, 0, 0);

        // Four in flight: no further pops until a response arrives.
        enable_i = 1'b1;
        repeat (3) begin
            step(1);
            check("throttle_pop", 64'(fifo_read_o), 64'(0));
        end
        check("throttle_out", 64'(outstanding_o), 64'(4));
        enable_i = 1'b0;
        respond(1);
        check("rsp_out", 64'(outstanding_o), 64'(3));
        issue_one("resume_hs_rsp", 1'b1, 40'h0000_5000, 1'b0, 40'h0000_5040, 0, 0, 1, 1, 0);

        // Flush aborts a stalled request; counters survive.
        issue_one("flush", 1'b1, 40'h0000_6000, 1'b0, 40'h0000_6040, 0, 0, 0, 0, 0);
        flush_i = 1'b1;
        step(1);
        flush_i = 1'b0;
        check("flush_valid", 64'(pf_req_valid_o), 64'(0));
        check("flush_out", 64'(outstanding_o), 64'(3));
        step(1);
        issue_one("post_flush", 1'b1, 40'h0000_7000, 1'b0, 40'h0000_7040, 0, 0, 1, 0, 0);
        respond(4);
        check("drain_out", 64'(outstanding_o), 64'(0));
        respond(1);
        check("rsp_at_zero", 64'(outstanding_o), 64'(0));
        issue_one("hs_flush", 1'b1, 40'h0000_8000, 1'b0, 40'h0000_8040, 0, 0, 1, 0, 1);
        issue_one("after_hs_flush", 1'b1, 40'h0000_9000, 1'b0, 40'h0000_9040, 0, 0, 1, 0, 0);

        // Asynchronous reset while a request is presented.
        issue_one("rst_mid", 1'b1, 40'h0000_A000, 1'b0, 40'h0000_A040, 0, 0, 0, 0, 0);
        #2;
        rst_i = 1'b1;
        #1;
        check("arst_valid", 64'(pf_req_valid_o), 64'(0));
        check("arst_addr", 64'(pf_req_addr_o), 64'(0));
        check("arst_tid", 64'(pf_req_tid_o), 64'(0));
        check("arst_out", 64'(outstanding_o), 64'(0));
        check("arst_read", 64'(fifo_read_o), 64'(0));
        check("arst_drop", 64'(dropped_o), 64'(0));
        @(posedge clk_i);
        #1;
        rst_i   = 1'b0;
        exp_tid = '0;
        exp_out = '0;
        respond(1);
        check("arst_rsp_out", 64'(outstanding_o), 64'(0));

        // 129 issues: IDs run 0..127 and wrap back to 0.
        for (int i = 0; i < 129; i++) begin
            issue_one("tidwrap", 1'b1, 40'h1_0080 + 40'(i) * 40'h1000, 1'b0,
                      40'h1_00C0 + 40'(i) * 40'h1000, 0, 0, 1, 0, 0);
            respond(1);
        end
        check("tidwrap_final", 64'(exp_tid), 64'(1));

        step(2);
        check("sb_drain", 64'(sb.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
